// File: rtl/pep_ks_common_param_pkg.sv
// -----------------------------------------------------------------------------
// pep_ks_common_param_pkg
// Shared key-switch parameters and types:
//   - ks_cmd_t / KS_CMD_W : key-switch command layout (batch tag, pointers,
//     ks_loop column offset).
//   - KS_BLOCK_COL_NB     : number of column commands expanded from a batch.
//   - LBX                 : ks_loop stride between consecutive columns.
//   - issuer_state_e      : command issuer FSM states.
//   - ISSUER_ERR_*        : bit positions inside issuer_error.
// -----------------------------------------------------------------------------
package pep_ks_common_param_pkg;

  localparam int KS_BLOCK_COL_NB = 4;
  localparam int LBX             = 3;
  localparam int KS_LOOP_W       = 8;
  localparam int KS_PTR_W        = 6;
  localparam int KS_TAG_W        = 4;
  localparam int KS_COL_W        = (KS_BLOCK_COL_NB > 1) ? $clog2(KS_BLOCK_COL_NB) : 1;

  typedef struct packed {
    logic [KS_TAG_W-1:0]  tag;
    logic [KS_PTR_W-1:0]  rp;
    logic [KS_PTR_W-1:0]  wp;
    logic [KS_LOOP_W-1:0] ks_loop;
  } ks_cmd_t;

  localparam int KS_CMD_W = $bits(ks_cmd_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } issuer_state_e;

  localparam int ISSUER_ERR_W          = 2;
  localparam int ISSUER_ERR_CREDIT_OVF = 0;
  localparam int ISSUER_ERR_PUSH_FULL  = 1;

  // Column index to ks_loop offset.
  function automatic logic [KS_LOOP_W-1:0] col_ks_loop(input logic [KS_COL_W-1:0] col);
    return KS_LOOP_W'(col) * KS_LOOP_W'(LBX);
  endfunction

endpackage

// File: rtl/pep_ks_batch_fifo.sv
// -----------------------------------------------------------------------------
// pep_ks_batch_fifo
// Small circular FIFO holding batch commands. The head entry is read straight
// from storage flops, so no input reaches the output combinationally.
//   clk, a_rst      : clock, asynchronous active-high reset
//   flush           : empties the FIFO; a push in the same cycle is kept
//   push, push_data : write request (ignored when full)
//   pop             : discard head entry (ignored when empty)
//   head            : current head entry (valid when !empty)
//   empty, full     : occupancy flags
// -----------------------------------------------------------------------------
module pep_ks_batch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         a_rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_addr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // A flush restarts the ring at slot 0, so a simultaneous push lands there.
  assign wr_addr = flush ? '0 : wr_ptr;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; the occupancy counter alone decides validity,
  // and leaving the array unreset keeps it mappable to plain flops/LUT-RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_addr] <= push_data;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? ptr_inc('0) : '0;
      cnt    <= do_push ? CNT_W'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pep_ks_cmd_issuer.sv
// -----------------------------------------------------------------------------
// pep_ks_cmd_issuer
// Expands buffered batch commands into KS_BLOCK_COL_NB column commands, one per
// unit of enquiry credit. Each column copies the batch fields and sets
// ks_loop = col*LBX.
//
// Ports:
//   clk                : clock
//   a_rst              : asynchronous active-high reset; release is expected
//                        to be synchronous to clk (upstream synchronizer)
//   reset_cache        : synchronous flush of FIFO, credit and column state
//   batch_in_cmd       : batch command (its ks_loop field is ignored)
//   batch_in_vld/_rdy  : batch valid/ready handshake
//   ks_seq_cmd_enquiry : one-cycle request for one column command
//   seq_ks_cmd         : registered column command, held between pulses
//   seq_ks_cmd_avail   : one-cycle pulse qualifying seq_ks_cmd
//   issuer_error       : sticky errors {push while full, credit overflow}
//
// Build option:
//   PEP_KS_CMD_ISSUER_ERROR_EN : compiles in error tracking; when undefined
//   issuer_error is tied to 0 (credit saturation/drop behaviour unchanged).
// -----------------------------------------------------------------------------
module pep_ks_cmd_issuer
  import pep_ks_common_param_pkg::*;
#(
  parameter int BATCH_FIFO_DEPTH = 4,
  parameter int ENQ_CNT_W        = 4
) (
  input  logic                    clk,
  input  logic                    a_rst,
  input  logic                    reset_cache,
  input  logic [KS_CMD_W-1:0]     batch_in_cmd,
  input  logic                    batch_in_vld,
  output logic                    batch_in_rdy,
  input  logic                    ks_seq_cmd_enquiry,
  output logic [KS_CMD_W-1:0]     seq_ks_cmd,
  output logic                    seq_ks_cmd_avail,
  output logic [ISSUER_ERR_W-1:0] issuer_error
);

  localparam logic [ENQ_CNT_W-1:0] ENQ_CNT_MAX = '1;

  issuer_state_e         state;
  logic [KS_COL_W-1:0]   col;
  ks_cmd_t               batch_r;
  ks_cmd_t               fifo_head;
  ks_cmd_t               issue_cmd;
  logic [ENQ_CNT_W-1:0]  enq_cnt;
  logic                  rdy_en;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_push;
  logic                  issue;
  logic                  last_col;
  logic                  load;
  logic                  enq_take;

  // ---------------------------------------------------------------------------
  // Batch FIFO
  // ---------------------------------------------------------------------------
  // rdy_en keeps batch_in_rdy low through reset and for the first cycle after
  // release.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  assign batch_in_rdy = rdy_en && !fifo_full;
  assign fifo_push    = batch_in_vld && batch_in_rdy;

  pep_ks_batch_fifo #(
    .DEPTH (BATCH_FIFO_DEPTH),
    .W     (KS_CMD_W)
  ) u_fifo (
    .clk       (clk),
    .a_rst     (a_rst),
    .flush     (reset_cache),
    .push      (fifo_push),
    .push_data (batch_in_cmd),
    .pop       (load),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // ---------------------------------------------------------------------------
  // Issue / load decisions
  // ---------------------------------------------------------------------------
  // Credit is read from the registered counter, so an enquiry only becomes
  // usable on the following cycle.
  assign issue    = (state == ST_RUN) && (enq_cnt != '0) && !reset_cache;
  assign last_col = (col == KS_COL_W'(KS_BLOCK_COL_NB - 1));
  // Load from IDLE, or chain straight into the next batch on the last column
  // so back-to-back batches issue with no bubble.
  assign load     = !reset_cache && !fifo_empty &&
                    ((state == ST_IDLE) || (issue && last_col));
  assign enq_take = ks_seq_cmd_enquiry && !reset_cache;

  // NOTE: every always_comb output gets a full default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    issue_cmd         = batch_r;
    issue_cmd.ks_loop = col_ks_loop(col);
  end

  // ---------------------------------------------------------------------------
  // FSM with registered command outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state            <= ST_IDLE;
      col              <= '0;
      batch_r          <= '0;
      seq_ks_cmd       <= '0;
      seq_ks_cmd_avail <= 1'b0;
    end else begin
      seq_ks_cmd_avail <= issue;
      if (issue) seq_ks_cmd <= issue_cmd;

      if (reset_cache) begin
        state <= ST_IDLE;
        col   <= '0;
      end else begin
        if (load) batch_r <= fifo_head;
        case (state)
          ST_IDLE: begin
            if (load) begin
              state <= ST_RUN;
              col   <= '0;
            end
          end
          ST_RUN: begin
            if (issue) begin
              if (last_col) begin
                col   <= '0;
                state <= load ? ST_RUN : ST_IDLE;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Enquiry credit counter (saturating; enquiries at saturation are dropped)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      enq_cnt <= '0;
    end else if (reset_cache) begin
      enq_cnt <= '0;
    end else if (enq_take && !issue) begin
      if (enq_cnt != ENQ_CNT_MAX) enq_cnt <= enq_cnt + 1'b1;
    end else if (!enq_take && issue) begin
      enq_cnt <= enq_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error tracking
  // ---------------------------------------------------------------------------
`ifdef PEP_KS_CMD_ISSUER_ERROR_EN
  logic [ISSUER_ERR_W-1:0] err_r;
  logic                    blocked_q;
  logic [KS_CMD_W-1:0]     blocked_cmd_q;
  logic                    blocked_now;
  logic                    credit_drop;

  assign blocked_now = batch_in_vld && !batch_in_rdy;
  assign credit_drop = enq_take && !issue && (enq_cnt == ENQ_CNT_MAX);

  // A producer holding vld against rdy=0 is legal; changing the command while
  // still blocked means the previous one was lost upstream.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      err_r         <= '0;
      blocked_q     <= 1'b0;
      blocked_cmd_q <= '0;
    end else begin
      blocked_q     <= blocked_now;
      blocked_cmd_q <= batch_in_cmd;
      if (credit_drop) err_r[ISSUER_ERR_CREDIT_OVF] <= 1'b1;
      if (blocked_now && blocked_q && (batch_in_cmd != blocked_cmd_q))
        err_r[ISSUER_ERR_PUSH_FULL] <= 1'b1;
    end
  end

  assign issuer_error = err_r;
`else
  assign issuer_error = '0;
`endif

endmodule

// File: tb/tb_pep_ks_cmd_issuer.sv
`timescale 1ns/1ps
module tb_pep_ks_cmd_issuer;
  import pep_ks_common_param_pkg::*;

`ifdef PEP_KS_CMD_ISSUER_ERROR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // Hand-computed ks_loop per column (LBX = 3).
  localparam logic [7:0] KS_LOOP_EXP [4] = '{8'd0, 8'd3, 8'd6, 8'd9};

  logic                clk = 1'b0;
  logic                a_rst;
  logic                reset_cache;
  logic [KS_CMD_W-1:0] batch_in_cmd;
  logic                batch_in_vld;
  logic                batch_in_rdy;
  logic                ks_seq_cmd_enquiry;
  logic [KS_CMD_W-1:0] seq_ks_cmd;
  logic                seq_ks_cmd_avail;
  logic [1:0]          issuer_error;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    ks_cmd_t cmd;
    int      at;
  } exp_t;

  exp_t                exp_q[$];
  exp_t                mon_e;
  logic [KS_CMD_W-1:0] last_cmd = '0;

  pep_ks_cmd_issuer #(
    .BATCH_FIFO_DEPTH (4),
    .ENQ_CNT_W        (4)
  ) dut (
    .clk                (clk),
    .a_rst              (a_rst),
    .reset_cache        (reset_cache),
    .batch_in_cmd       (batch_in_cmd),
    .batch_in_vld       (batch_in_vld),
    .batch_in_rdy       (batch_in_rdy),
    .ks_seq_cmd_enquiry (ks_seq_cmd_enquiry),
    .seq_ks_cmd         (seq_ks_cmd),
    .seq_ks_cmd_avail   (seq_ks_cmd_avail),
    .issuer_error       (issuer_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got cycle %0d, want finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor: away from the rising edge.
  always @(negedge clk) begin
    if (a_rst) begin
      last_cmd <= '0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        fail_now("missing_pulse", cyc, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (seq_ks_cmd_avail) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_pulse", cyc, -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_cmd", seq_ks_cmd, mon_e.cmd);
          check("pulse_cycle", cyc, mon_e.at);
        end
        last_cmd <= seq_ks_cmd;
      end else begin
        check("cmd_hold", seq_ks_cmd, last_cmd);
      end
    end
  end

  function automatic ks_cmd_t mkb(input int tag, input int rp, input int wp);
    ks_cmd_t b;
    b.tag     = KS_TAG_W'(tag);
    b.rp      = KS_PTR_W'(rp);
    b.wp      = KS_PTR_W'(wp);
    b.ks_loop = 8'hA5;
    return b;
  endfunction

  function automatic ks_cmd_t mkc(input ks_cmd_t b, input int col);
    ks_cmd_t c;
    c         = b;
    c.ks_loop = KS_LOOP_EXP[col];
    return c;
  endfunction

  task automatic expect_pulse(input ks_cmd_t b, input int col, input int at);
    exp_t e;
    e.cmd = mkc(b, col);
    e.at  = at;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  // p = cycle in which vld is driven; the accepting edge is p+1.
  task automatic push_batch(input ks_cmd_t c, output int p);
    int n;
    n            = 0;
    batch_in_vld = 1'b1;
    batch_in_cmd = c;
    while (!batch_in_rdy && n < 100) begin
      tick();
      n++;
    end
    if (!batch_in_rdy) fail_now("push_timeout", n, 100);
    p = cyc;
    tick();
    batch_in_vld = 1'b0;
  endtask

  task automatic enquire(input int n);
    ks_seq_cmd_enquiry = 1'b1;
    repeat (n) tick();
    ks_seq_cmd_enquiry = 1'b0;
  endtask

  ks_cmd_t ba, bb, bc1, bc2, bd1, bd2, bd3, bz;
  ks_cmd_t bg [5];
  int      p, p2, k;

  initial begin
    a_rst              = 1'b1;
    reset_cache        = 1'b0;
    batch_in_vld       = 1'b0;
    batch_in_cmd       = '0;
    ks_seq_cmd_enquiry = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_avail", seq_ks_cmd_avail, 0);
    check("rst_cmd", seq_ks_cmd, 0);
    check("rst_err", issuer_error, 0);
    check("rst_rdy", batch_in_rdy, 0);
    a_rst = 1'b0;
    check("rdy_at_release", batch_in_rdy, 0);
    tick();
    check("rdy_after_release", batch_in_rdy, 1);

    // One batch, spaced enquiries
    ba = mkb(1, 0, 3);
    push_batch(ba, p);
    wait_cyc(p + 4);
    for (int c = 0; c < KS_BLOCK_COL_NB; c++) begin
      k = cyc;
      expect_pulse(ba, c, k + 2);
      enquire(1);
      repeat (9) tick();
    end
    check("a_idle", dut.state, ST_IDLE);

    // Credit held before any batch
    enquire(3);
    check("b_cnt3", dut.enq_cnt, 3);
    repeat (3) tick();
    bb = mkb(2, 5, 9);
    push_batch(bb, p);
    for (int c = 0; c < 3; c++) expect_pulse(bb, c, p + 3 + c);
    wait_cyc(p + 7);
    check("b_cnt0", dut.enq_cnt, 0);
    k = cyc;
    expect_pulse(bb, 3, k + 2);
    enquire(1);
    wait_cyc(k + 5);
    check("b_idle", dut.state, ST_IDLE);

    // Two queued batches, continuous enquiry
    bc1 = mkb(3, 10, 20);
    bc2 = mkb(4, 30, 40);
    push_batch(bc1, p);
    push_batch(bc2, p2);
    repeat (4) tick();
    k = cyc;
    for (int i = 0; i < 2 * KS_BLOCK_COL_NB; i++)
      expect_pulse((i < KS_BLOCK_COL_NB) ? bc1 : bc2, i % KS_BLOCK_COL_NB, k + 2 + i);
    enquire(2 * KS_BLOCK_COL_NB);
    wait_cyc(k + 12);
    check("c_idle", dut.state, ST_IDLE);
    check("c_cnt0", dut.enq_cnt, 0);

    // reset_cache mid-batch with simultaneous push and enquiry
    bd1 = mkb(5, 1, 2);
    bd2 = mkb(6, 3, 4);
    bd3 = mkb(7, 7, 7);
    enquire(3);
    push_batch(bd1, p);
    push_batch(bd2, p2);
    expect_pulse(bd1, 0, p + 3);
    wait_cyc(p + 3);
    check("d_col1", dut.col, 1);
    check("d_cnt2", dut.enq_cnt, 2);
    check("d_rdy", batch_in_rdy, 1);
    reset_cache        = 1'b1;
    batch_in_vld       = 1'b1;
    batch_in_cmd       = bd3;
    ks_seq_cmd_enquiry = 1'b1;
    tick();
    reset_cache        = 1'b0;
    batch_in_vld       = 1'b0;
    ks_seq_cmd_enquiry = 1'b0;
    check("d_no_pulse", seq_ks_cmd_avail, 0);
    check("d_cnt_flushed", dut.enq_cnt, 0);
    check("d_col_flushed", dut.col, 0);
    check("d_state_idle", dut.state, ST_IDLE);
    for (int c = 0; c < KS_BLOCK_COL_NB; c++) begin
      k = cyc;
      expect_pulse(bd3, c, k + 2);
      enquire(1);
      repeat (3) tick();
    end
    enquire(1);
    repeat (6) tick();
    check("d_held_credit", dut.enq_cnt, 1);
    reset_cache = 1'b1;
    tick();
    reset_cache = 1'b0;
    check("d_cnt_cleared", dut.enq_cnt, 0);

    // Credit saturation
    enquire(16);
    check("f_cnt_sat", dut.enq_cnt, 15);
    check("f_err_ovf", issuer_error[0], ERR_EN);
    check("f_err_full_clear", issuer_error[1], 0);
    reset_cache = 1'b1;
    tick();
    reset_cache = 1'b0;
    check("f_cnt_cleared", dut.enq_cnt, 0);
    check("f_err_sticky", issuer_error[0], ERR_EN);

    // Fill FIFO, then change command while blocked
    for (int i = 0; i < 5; i++) begin
      bg[i] = mkb(8 + i, i, i + 1);
      push_batch(bg[i], p);
    end
    check("g_rdy_full", batch_in_rdy, 0);
    batch_in_vld = 1'b1;
    batch_in_cmd = mkb(14, 1, 1);
    tick();
    batch_in_cmd = mkb(15, 2, 2);
    tick();
    batch_in_vld = 1'b0;
    check("g_err_push_full", issuer_error[1], ERR_EN);
    check("g_rdy_still_full", batch_in_rdy, 0);

    // Asynchronous reset mid-stream
    k = cyc;
    expect_pulse(bg[0], 0, k + 2);
    ks_seq_cmd_enquiry = 1'b1;
    tick();
    tick();
    tick();
    check("h_avail_pre", seq_ks_cmd_avail, 1);
    #1;
    a_rst              = 1'b1;
    ks_seq_cmd_enquiry = 1'b0;
    #1;
    check("h_avail_drop", seq_ks_cmd_avail, 0);
    check("h_cmd_zero", seq_ks_cmd, 0);
    check("h_rdy_zero", batch_in_rdy, 0);
    check("h_err_zero", issuer_error, 0);
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
    check("h_rdy_at_release", batch_in_rdy, 0);
    check("h_cnt_zero", dut.enq_cnt, 0);
    tick();
    check("h_rdy_after_release", batch_in_rdy, 1);
    repeat (8) tick();
    enquire(1);
    repeat (5) tick();
    bz = mkb(3, 33, 44);
    push_batch(bz, p);
    expect_pulse(bz, 0, p + 3);
    wait_cyc(p + 6);

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
